// File: rtl/axi4_wr_arbiter.sv
// rtl/axi4_wr_arbiter.sv - two-master round-robin arbiter for the AXI4 write path
module axi4_wr_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int SIZE_W = 3
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [1:0]          M_AWVALID,
    output logic [1:0]          M_AWREADY,
    input  logic [2*ADDR_W-1:0] M_AWADDR,
    input  logic [2*LEN_W-1:0]  M_AWLEN,
    input  logic [2*SIZE_W-1:0] M_AWSIZE,
    input  logic [1:0]          M_WVALID,
    output logic [1:0]          M_WREADY,
    input  logic [2*DATA_W-1:0] M_WDATA,
    input  logic [1:0]          M_WLAST,
    output logic [1:0]          M_BVALID,
    input  logic [1:0]          M_BREADY,
    output logic [3:0]          M_BRESP,
    output logic                S_AWVALID,
    input  logic                S_AWREADY,
    output logic [ADDR_W-1:0]   S_AWADDR,
    output logic [LEN_W-1:0]    S_AWLEN,
    output logic [SIZE_W-1:0]   S_AWSIZE,
    output logic                S_WVALID,
    input  logic                S_WREADY,
    output logic [DATA_W-1:0]   S_WDATA,
    output logic                S_WLAST,
    input  logic                S_BVALID,
    output logic                S_BREADY,
    input  logic [1:0]          S_BRESP
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;

    // Next-state: pick a master in IDLE, then walk AW -> W -> B for that one burst
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (M_AWVALID != 2'b00) begin
                    // A tie goes to whoever was not served last; otherwise the lone requester
                    grant_d = (M_AWVALID == 2'b11) ? ~last_grant_q : M_AWVALID[1];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (S_AWVALID && S_AWREADY) state_d = DATA;
            end
            DATA: begin
                // The master's WLAST closes the data phase; beats are not counted
                if (S_WVALID && S_WREADY && S_WLAST) state_d = RESP;
            end
            RESP: begin
                if (S_BVALID && S_BREADY) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves master 0 as the winner of the first tie
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Channel routing: only the channel of the current phase passes, all else is held at 0
    always_comb begin
        S_AWVALID = 1'b0;
        S_AWADDR  = '0;
        S_AWLEN   = '0;
        S_AWSIZE  = '0;
        S_WVALID  = 1'b0;
        S_WDATA   = '0;
        S_WLAST   = 1'b0;
        S_BREADY  = 1'b0;
        M_AWREADY = 2'b00;
        M_WREADY  = 2'b00;
        M_BVALID  = 2'b00;
        M_BRESP   = 4'b0000;
        case (state_q)
            ADDR: begin
                S_AWVALID = M_AWVALID[grant_q];
                S_AWADDR  = grant_q ? M_AWADDR[2*ADDR_W-1:ADDR_W] : M_AWADDR[ADDR_W-1:0];
                S_AWLEN   = grant_q ? M_AWLEN[2*LEN_W-1:LEN_W]    : M_AWLEN[LEN_W-1:0];
                S_AWSIZE  = grant_q ? M_AWSIZE[2*SIZE_W-1:SIZE_W] : M_AWSIZE[SIZE_W-1:0];
                M_AWREADY[grant_q] = S_AWREADY;
            end
            DATA: begin
                S_WVALID = M_WVALID[grant_q];
                S_WDATA  = grant_q ? M_WDATA[2*DATA_W-1:DATA_W] : M_WDATA[DATA_W-1:0];
                S_WLAST  = M_WLAST[grant_q];
                M_WREADY[grant_q] = S_WREADY;
            end
            RESP: begin
                M_BVALID[grant_q] = S_BVALID;
                M_BRESP           = {S_BRESP, S_BRESP};
                S_BREADY          = M_BREADY[grant_q];
            end
            default: ;
        endcase
    end

endmodule
